// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: control FSM states, opcodes and
// datapath mux/ALU select codes used by both the control unit and the datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StRWb,
    StBranch,
    StJump,
    StHalt,
    StIllegal
  } state_e;

  localparam int unsigned OpRType = 'h00;
  localparam int unsigned OpAddi  = 'h01;
  localparam int unsigned OpLw    = 'h02;
  localparam int unsigned OpSw    = 'h03;
  localparam int unsigned OpBeq   = 'h04;
  localparam int unsigned OpBne   = 'h05;
  localparam int unsigned OpJmp   = 'h06;
  localparam int unsigned OpHalt  = 'h7F;

  typedef enum logic [2:0] {
    AluAdd   = 3'd0,
    AluSub   = 3'd1,
    AluFunct = 3'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBReg   = 2'd0,
    SrcBTwo   = 2'd1,
    SrcBImm   = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'd0,
    PcSrcAluOut = 2'd1,
    PcSrcJump   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the multicycle CPU, with a sticky illegal-opcode flag
// and a retired-instruction counter.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 7
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_zero,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           IorD,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           MemToReg,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           illegal,
  output logic [15:0]    retired
);

  state_e      state_q, state_d;
  logic        is_bne_q;
  logic        illegal_q;
  logic [15:0] retired_q;
  logic        retire;

  // Every completing state returns to FETCH, so leaving one retires an instruction.
  assign retire = state_q inside {StRWb, StMemWb, StMemWrite, StBranch, StJump};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= StReset;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      // Branch sense is latched at DECODE so opcode may change afterwards.
      if (state_q == StDecode) is_bne_q <= (opcode == OPW'(OpBne));
      if (state_d == StIllegal) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        if      (opcode == OPW'(OpRType)) state_d = StExecR;
        else if (opcode == OPW'(OpAddi))  state_d = StExecI;
        else if (opcode == OPW'(OpLw))    state_d = StMemAddr;
        else if (opcode == OPW'(OpSw))    state_d = StMemAddr;
        else if (opcode == OPW'(OpBeq))   state_d = StBranch;
        else if (opcode == OPW'(OpBne))   state_d = StBranch;
        else if (opcode == OPW'(OpJmp))   state_d = StJump;
        else if (opcode == OPW'(OpHalt))  state_d = StHalt;
        else                              state_d = StIllegal;
      end
      StExecR:    state_d = StRWb;
      StExecI:    state_d = StRWb;
      StMemAddr: begin
        if      (opcode == OPW'(OpLw)) state_d = StMemRead;
        else if (opcode == OPW'(OpSw)) state_d = StMemWrite;
        else                           state_d = StIllegal;
      end
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StRWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StHalt:     state_d = StHalt;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StIllegal;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SrcBReg;
    ALUOp    = AluAdd;
    PCSource = PcSrcAlu;
    unique case (state_q)
      StFetch: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SrcBTwo;
      end
      StDecode: ALUSrcB = SrcBImm;
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
      end
      StExecI, StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StMemRead: IorD = 1'b1;
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWrite: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = AluSub;
        PCSource = PcSrcAluOut;
        PCWrite  = is_bne_q ? ~alu_zero : alu_zero;
      end
      StJump: begin
        PCSource = PcSrcJump;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control words are queued
// per instruction and popped against the DUT outputs on each falling edge.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        alu_zero = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemWrite, RegWrite, MemToReg, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        illegal;
  logic [15:0] retired;
  logic [30:0] got;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_retired = 16'h0000;
  logic [30:0] sb[$];

  control_unit #(.OPW(7)) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .opcode   (opcode),
    .alu_zero (alu_zero),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .illegal  (illegal),
    .retired  (retired)
  );

  assign got = {illegal, retired, PCWrite, IRWrite, IorD, MemWrite, RegWrite, MemToReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSource};

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [30:0] obs, input logic [30:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] cv(input logic pcw, input logic irw, input logic iord,
                                     input logic mw, input logic rw, input logic m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [2:0] aop, input logic [1:0] pcs);
    return {pcw, irw, iord, mw, rw, m2r, asa, asb, aop, pcs};
  endfunction

  // Runs one instruction from a falling edge in FETCH; abort_at asserts reset in that cycle.
  task automatic run_instr(input logic [6:0] op, input logic zero, input int abort_at);
    logic [13:0] seq[$];
    logic [13:0] fetch_v, dec_v;
    logic [30:0] exp;
    logic        retiring, ill, mem, br;
    fetch_v  = cv(1, 1, 0, 0, 0, 0, 0, 2'd1, 3'd0, 2'd0);
    dec_v    = cv(0, 0, 0, 0, 0, 0, 0, 2'd2, 3'd0, 2'd0);
    retiring = 1'b1;
    ill      = 1'b0;
    mem      = (op == 7'h02) || (op == 7'h03);
    seq.push_back(fetch_v);
    seq.push_back(dec_v);
    case (op)
      7'h00: begin
        seq.push_back(cv(0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd2, 2'd0));
        seq.push_back(cv(0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0));
      end
      7'h01: begin
        seq.push_back(cv(0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0));
        seq.push_back(cv(0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0));
      end
      7'h02: begin
        seq.push_back(cv(0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0));
        seq.push_back(cv(0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0));
        seq.push_back(cv(0, 0, 0, 0, 1, 1, 0, 2'd0, 3'd0, 2'd0));
      end
      7'h03: begin
        seq.push_back(cv(0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0));
        seq.push_back(cv(0, 0, 1, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0));
      end
      7'h04, 7'h05: begin
        br = (op == 7'h04) ? zero : ~zero;
        seq.push_back(cv(br, 0, 0, 0, 0, 0, 1, 2'd0, 3'd1, 2'd1));
      end
      7'h06: seq.push_back(cv(1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2));
      default: begin
        retiring = 1'b0;
        ill      = (op != 7'h7F);
        repeat (4) seq.push_back(14'h0000);
      end
    endcase
    foreach (seq[i]) sb.push_back({ill && (i >= 2), exp_retired, seq[i]});
    for (int c = 0; c < seq.size(); c++) begin
      opcode   = (c == 1 || (mem && c == 2)) ? op : 7'h55;
      alu_zero = zero;
      #1;
      if (sb.size() == 0) begin
        check_eq("sb_empty", got, 31'h7FFFFFFF);
      end else begin
        exp = sb.pop_front();
        check_eq($sformatf("op%02h_z%0d_c%0d", op, zero, c + 1), got, exp);
      end
      if (c == abort_at) begin
        RST_n = 1'b0;
        #1;
        check_eq($sformatf("abort_op%02h_c%0d", op, c + 1), got, 31'h0);
        exp_retired = 16'h0000;
        sb.delete();
        return;
      end
      @(negedge CLK);
    end
    if (retiring) exp_retired = exp_retired + 16'd1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic do_reset(input string tag);
    RST_n = 1'b0;
    #1;
    check_eq(tag, got, 31'h0);
    exp_retired = 16'h0000;
    release_reset();
  endtask

  initial begin
    @(negedge CLK);
    #1;
    check_eq("reset_state", got, 31'h0);
    release_reset();

    run_instr(7'h00, 1'b0, -1);
    run_instr(7'h01, 1'b1, -1);
    run_instr(7'h02, 1'b0, -1);
    run_instr(7'h03, 1'b0, -1);
    run_instr(7'h04, 1'b1, -1);
    run_instr(7'h04, 1'b0, -1);
    run_instr(7'h05, 1'b1, -1);
    run_instr(7'h05, 1'b0, -1);
    run_instr(7'h06, 1'b0, -1);
    run_instr(7'h7F, 1'b0, -1);
    do_reset("reset_after_halt");

    run_instr(7'h55, 1'b0, -1);
    do_reset("reset_clears_illegal");
    run_instr(7'h7E, 1'b1, -1);
    do_reset("reset_after_illegal_7e");

    run_instr(7'h00, 1'b0, -1);
    run_instr(7'h03, 1'b0, 3);
    release_reset();
    run_instr(7'h06, 1'b0, -1);

    for (int i = 0; i < 25; i++) begin
      run_instr(7'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), -1);
    end

    // Counter wrap: preload the top value rather than retiring 65535 jumps.
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    run_instr(7'h06, 1'b0, -1);
    run_instr(7'h06, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OPW, default 7: opcode width, matching the instruction-register control field.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port RST_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  OPW  control field of the instruction register.
REQ-005 SHALL have port alu_zero  input  1  ALU zero flag for the current cycle.
REQ-006 SHALL have port PCWrite  output  1  PC update enable, already qualified by branch condition.
REQ-007 SHALL have port IRWrite  output  1  instruction register load enable.
REQ-008 SHALL have ports IorD / MemWrite / RegWrite / MemToReg / ALUSrcA  output  1 each: memory address select (0=PC, 1=ALUOut), memory write, register file write, writeback select (1=MDR), ALU A select (1=regA).
REQ-009 SHALL have ports ALUSrcB  output  2 (0=regB, 1=const 2, 2=imm), ALUOp  output  3 (0=add, 1=sub, 2=funct from IR), PCSource  output  2 (0=ALU result, 1=ALUOut, 2=imm jump target).
REQ-010 SHALL have ports illegal  output  1  sticky illegal-opcode flag; retired  output  16  retired-instruction count.

Function
REQ-011 SHALL implement a Moore FSM; every control output is a pure decode of the current state except PCWrite in BRANCH.
REQ-012 SHALL have states RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, HALT, ILLEGAL.
REQ-013 SHALL decode opcode: 0x00 R-type, 0x01 ADDI, 0x02 LW, 0x03 SW, 0x04 BEQ, 0x05 BNE, 0x06 JMP, 0x7F HALT; all other values are illegal.
REQ-014 RESET -> FETCH unconditionally; FETCH (IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0, PCWrite=1) -> DECODE.
REQ-015 DECODE (ALUSrcA=0, ALUSrcB=2, ALUOp=add, branch target precompute) SHALL branch on opcode: R->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, JMP->JUMP, HALT->HALT, illegal->ILLEGAL.
REQ-016 EXEC_R (ALUSrcA=1, ALUSrcB=0, ALUOp=2) -> R_WB; EXEC_I (ALUSrcA=1, ALUSrcB=2, ALUOp=add) -> R_WB; R_WB (RegWrite=1, MemToReg=0) -> FETCH.
REQ-017 MEM_ADDR (ALUSrcA=1, ALUSrcB=2, ALUOp=add) -> MEM_READ for LW, MEM_WRITE for SW; MEM_READ (IorD=1) -> MEM_WB; MEM_WB (RegWrite=1, MemToReg=1) -> FETCH; MEM_WRITE (IorD=1, MemWrite=1) -> FETCH.
REQ-018 BRANCH (ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1) SHALL assert PCWrite = alu_zero for BEQ, ~alu_zero for BNE, then -> FETCH.
REQ-019 JUMP (PCSource=2, PCWrite=1) -> FETCH.
REQ-020 Cycle counts SHALL be: R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 3.
REQ-021 opcode SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL be ignored.
REQ-022 HALT SHALL be absorbing with all outputs 0 until reset.
REQ-023 ILLEGAL SHALL set illegal=1, drive all outputs 0, and be absorbing until reset.
REQ-024 retired SHALL increment by 1 on each transition into FETCH from R_WB, MEM_WB, MEM_WRITE, BRANCH or JUMP; it wraps 0xFFFF->0x0000 and does not count HALT.
REQ-025 Any output not listed for a state SHALL be 0 in that state.

Reset
REQ-026 RST_n low SHALL force state RESET, retired=0, illegal=0 immediately, regardless of CLK.
REQ-027 In RESET all control outputs SHALL be 0; the first rising edge after RST_n rises enters FETCH.
REQ-028 Reset asserted mid-instruction (including MEM_WRITE) SHALL deassert MemWrite/RegWrite/PCWrite combinationally with no partial commit afterwards.

Structure
REQ-029 State encoding, opcode constants, and ALUOp/ALUSrcB/PCSource encodings SHALL live in a shared package cpu_pkg used by the datapath.
REQ-030 The module SHALL be flat; the retired counter SHALL not be a separate sub-module.

Verification
REQ-031 Reset, then opcode=0x00 held: states RESET,FETCH,DECODE,EXEC_R,R_WB; RegWrite=1 only in cycle 4; retired=1 at the next FETCH.
REQ-032 opcode=0x02: IorD=1 in MEM_ADDR+1 (MEM_READ), MemToReg=RegWrite=1 in cycle 5; opcode=0x03: MemWrite=1 exactly one cycle (cycle 4).
REQ-033 opcode=0x04 with alu_zero=1 -> PCWrite=1, PCSource=1 in cycle 3; alu_zero=0 -> PCWrite=0; opcode=0x05 gives inverted results.
REQ-034 opcode=0x55 -> illegal=1 from cycle 3 onward, all outputs 0; RST_n pulse clears illegal to 0.
REQ-035 Preload retired=0xFFFF via 65535 JMPs, one more JMP -> retired=0x0000; RST_n low during MEM_WRITE -> MemWrite drops within same cycle, retired=0.
